// File: rtl/lector_bus_rtc_if.sv
// lector_bus_rtc_if
//   Groups the signals between the RTC read sequencer, the RTC control FSM
//   and the bidirectional AD-bus pad logic.
//   master : controller / pad side (drives start, address and pad input value)
//   slave  : the read sequencer (drives the bus, the strobes and the result)
//   Signals:
//     inicio         start request
//     direccion      RTC register address to read
//     bus_entrada    value currently present on the AD bus pads
//     bus_salida     value to drive onto the AD bus
//     bus_habilitado pad output enable (1 = drive bus_salida)
//     cs_n/ad_n/wr_n/rd_n  active-low chip select and strobes
//     dato_leido     last byte read
//     dato_valido    one-cycle pulse when dato_leido has been updated
//     ocupado        transaction in progress
interface lector_bus_rtc_if;
   logic       inicio;
   logic [7:0] direccion;
   logic [7:0] bus_entrada;
   logic [7:0] bus_salida;
   logic       bus_habilitado;
   logic       cs_n;
   logic       ad_n;
   logic       wr_n;
   logic       rd_n;
   logic [7:0] dato_leido;
   logic       dato_valido;
   logic       ocupado;

   modport master (
      output inicio, direccion, bus_entrada,
      input  bus_salida, bus_habilitado, cs_n, ad_n, wr_n, rd_n,
             dato_leido, dato_valido, ocupado
   );

   modport slave (
      input  inicio, direccion, bus_entrada,
      output bus_salida, bus_habilitado, cs_n, ad_n, wr_n, rd_n,
             dato_leido, dato_valido, ocupado
   );
endinterface

// File: rtl/lector_bus_rtc.sv
// lector_bus_rtc
//   Read sequencer for the multiplexed 8-bit address/data bus of the RTC chip.
//   A start request runs one read: address phase (address driven with the
//   ad_n/wr_n strobes), turnaround, RD strobe with capture of the returned
//   byte on the last cycle, and a recovery phase. The byte is then presented
//   with a one-cycle dato_valido pulse.
//   Parameter:
//     T_FASE  clock cycles per bus phase (>= 1)
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-high reset
//     bus    lector_bus_rtc_if.slave (see interface file for signal list)
//   All outputs come straight from flops: they are decoded from the next
//   state and registered, so the pads never see combinational glitches.
module lector_bus_rtc #(
   parameter int T_FASE = 4
) (
   input  logic              clk,
   input  logic              reset,
   lector_bus_rtc_if.slave   bus
);

   localparam int            CW     = (T_FASE > 1) ? $clog2(T_FASE) : 1;
   localparam logic [CW-1:0] ULTIMO = CW'(T_FASE - 1);

   typedef enum logic [2:0] {
      REPOSO,
      DIRECCION,
      LIBERA,
      LECTURA,
      FIN
   } estado_t;

   estado_t       estado_q, estado_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    dir_q, dir_d;
   logic [7:0]    dato_q, dato_d;
   logic [7:0]    salida_q, salida_d;
   logic          hab_q, hab_d;
   logic          cs_n_q, cs_n_d;
   logic          ad_n_q, ad_n_d;
   logic          wr_n_q, wr_n_d;
   logic          rd_n_q, rd_n_d;
   logic          valido_q, valido_d;
   logic          ocupado_q, ocupado_d;
   logic          fin_fase;

   assign fin_fase = (cnt_q == ULTIMO);

   // Next state, phase counter and captured data.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      estado_d = estado_q;
      dir_d    = dir_q;
      dato_d   = dato_q;
      valido_d = 1'b0;

      case (estado_q)
         REPOSO: begin
            if (bus.inicio) begin
               estado_d = DIRECCION;
               dir_d    = bus.direccion;
            end
         end
         DIRECCION: if (fin_fase) estado_d = LIBERA;
         LIBERA:    if (fin_fase) estado_d = LECTURA;
         LECTURA: begin
            if (fin_fase) begin
               estado_d = FIN;
               // Only the edge closing the last RD cycle samples the pads.
               dato_d   = bus.bus_entrada;
            end
         end
         FIN: begin
            if (fin_fase) begin
               estado_d = REPOSO;
               valido_d = 1'b1;
            end
         end
         default: estado_d = REPOSO;
      endcase

      // Counter restarts on every state change and rests at 0 in REPOSO.
      if (estado_d != estado_q || estado_q == REPOSO) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Output decode from the state being entered, so the registered outputs
   // line up exactly with the registered state.
   always_comb begin
      salida_d  = 8'h00;
      hab_d     = 1'b0;
      cs_n_d    = 1'b1;
      ad_n_d    = 1'b1;
      wr_n_d    = 1'b1;
      rd_n_d    = 1'b1;
      ocupado_d = (estado_d != REPOSO);

      case (estado_d)
         DIRECCION: begin
            cs_n_d   = 1'b0;
            ad_n_d   = 1'b0;
            wr_n_d   = 1'b0;
            hab_d    = 1'b1;
            salida_d = dir_d;
         end
         LIBERA:  cs_n_d = 1'b0;
         LECTURA: begin
            cs_n_d = 1'b0;
            rd_n_d = 1'b0;
         end
         default: ;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of the others.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado_q  <= REPOSO;
         cnt_q     <= '0;
         dir_q     <= 8'h00;
         dato_q    <= 8'h00;
         salida_q  <= 8'h00;
         hab_q     <= 1'b0;
         cs_n_q    <= 1'b1;
         ad_n_q    <= 1'b1;
         wr_n_q    <= 1'b1;
         rd_n_q    <= 1'b1;
         valido_q  <= 1'b0;
         ocupado_q <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         cnt_q     <= cnt_d;
         dir_q     <= dir_d;
         dato_q    <= dato_d;
         salida_q  <= salida_d;
         hab_q     <= hab_d;
         cs_n_q    <= cs_n_d;
         ad_n_q    <= ad_n_d;
         wr_n_q    <= wr_n_d;
         rd_n_q    <= rd_n_d;
         valido_q  <= valido_d;
         ocupado_q <= ocupado_d;
      end
   end

   assign bus.bus_salida     = salida_q;
   assign bus.bus_habilitado = hab_q;
   assign bus.cs_n           = cs_n_q;
   assign bus.ad_n           = ad_n_q;
   assign bus.wr_n           = wr_n_q;
   assign bus.rd_n           = rd_n_q;
   assign bus.dato_leido     = dato_q;
   assign bus.dato_valido    = valido_q;
   assign bus.ocupado        = ocupado_q;

endmodule

// File: tb/tb_lector_bus_rtc.sv
// tb_lector_bus_rtc
//   Bench for lector_bus_rtc with two instances: T_FASE=4 (dut_a) and
//   T_FASE=1 (dut_b). A transaction-level model tracks, per instance, how
//   many cycles have elapsed since a start was accepted; the expected bus
//   phase is derived from that age by division. One compare process checks
//   every output of both instances on every falling edge; directed sequences
//   add literal expectations for the key cycles.
module tb_lector_bus_rtc;

   localparam int TA = 4;
   localparam int TB = 1;

   logic clk;
   logic reset;

   lector_bus_rtc_if a ();
   lector_bus_rtc_if b ();

   lector_bus_rtc #(.T_FASE(TA)) dut_a (.clk(clk), .reset(reset), .bus(a));
   lector_bus_rtc #(.T_FASE(TB)) dut_b (.clk(clk), .reset(reset), .bus(b));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // age: -1 when idle, otherwise the cycle number within the transaction
   // (1 .. 4*T), counted from the accepting cycle 0.
   typedef struct {
      int         age;
      logic [7:0] addr;
      logic [7:0] dato;
      bit         valid;
   } mdl_t;

   typedef struct {
      logic [7:0] sal;
      logic       hab, cs, ad, wr, rd, ocu;
   } exp_t;

   function automatic mdl_t mdl_idle();
      mdl_t m;
      m.age   = -1;
      m.addr  = 8'h00;
      m.dato  = 8'h00;
      m.valid = 1'b0;
      return m;
   endfunction

   function automatic mdl_t mdl_step(input mdl_t m, input int t, input logic ini,
                                     input logic [7:0] dir, input logic [7:0] be);
      mdl_t n;
      n = m;
      n.valid = 1'b0;
      if (m.age < 0) begin
         if (ini) begin
            n.age  = 1;
            n.addr = dir;
         end
      end else begin
         if (m.age == 3 * t) n.dato = be;
         if (m.age == 4 * t) begin
            n.age   = -1;
            n.valid = 1'b1;
         end else begin
            n.age = m.age + 1;
         end
      end
      return n;
   endfunction

   function automatic exp_t predicted(input mdl_t m, input int t);
      exp_t e;
      e.sal = 8'h00; e.hab = 1'b0; e.cs = 1'b1; e.ad = 1'b1;
      e.wr  = 1'b1;  e.rd  = 1'b1; e.ocu = 1'b0;
      if (m.age > 0) begin
         e.ocu = 1'b1;
         case ((m.age - 1) / t)
            0: begin e.cs = 1'b0; e.ad = 1'b0; e.wr = 1'b0; e.hab = 1'b1; e.sal = m.addr; end
            1: e.cs = 1'b0;
            2: begin e.cs = 1'b0; e.rd = 1'b0; end
            default: ;
         endcase
      end
      return e;
   endfunction

   mdl_t ma, mb;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         ma <= mdl_idle();
         mb <= mdl_idle();
      end else begin
         ma <= mdl_step(ma, TA, a.inicio, a.direccion, a.bus_entrada);
         mb <= mdl_step(mb, TB, b.inicio, b.direccion, b.bus_entrada);
      end
   end

   task automatic cmp(input string tag, input mdl_t m, input int t,
                      input logic [7:0] sal, input logic hab, input logic cs,
                      input logic ad, input logic wr, input logic rd,
                      input logic [7:0] dl, input logic dv, input logic ocu);
      exp_t e;
      e = predicted(m, t);
      check({tag, ".bus_salida"},     {24'h0, sal}, {24'h0, e.sal});
      check({tag, ".bus_habilitado"}, {31'h0, hab}, {31'h0, e.hab});
      check({tag, ".cs_n"},           {31'h0, cs},  {31'h0, e.cs});
      check({tag, ".ad_n"},           {31'h0, ad},  {31'h0, e.ad});
      check({tag, ".wr_n"},           {31'h0, wr},  {31'h0, e.wr});
      check({tag, ".rd_n"},           {31'h0, rd},  {31'h0, e.rd});
      check({tag, ".ocupado"},        {31'h0, ocu}, {31'h0, e.ocu});
      check({tag, ".dato_leido"},     {24'h0, dl},  {24'h0, m.dato});
      check({tag, ".dato_valido"},    {31'h0, dv},  {31'h0, m.valid});
   endtask

   bit compare_on = 1'b0;

   always @(negedge clk) begin
      if (compare_on) begin
         cmp("a", ma, TA, a.bus_salida, a.bus_habilitado, a.cs_n, a.ad_n, a.wr_n,
             a.rd_n, a.dato_leido, a.dato_valido, a.ocupado);
         cmp("b", mb, TB, b.bus_salida, b.bus_habilitado, b.cs_n, b.ad_n, b.wr_n,
             b.rd_n, b.dato_leido, b.dato_valido, b.ocupado);
      end
   end

   // ---------------- stimulus ----------------
   int pulses;

   initial begin
      a.inicio = 1'b0; a.direccion = 8'h00; a.bus_entrada = 8'h00;
      b.inicio = 1'b0; b.direccion = 8'h00; b.bus_entrada = 8'h00;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      compare_on = 1'b1;
      check("reset_cs_n", {31'h0, a.cs_n}, 32'h1);
      check("reset_hab", {31'h0, a.bus_habilitado}, 32'h0);
      check("reset_dato", {24'h0, a.dato_leido}, 32'h0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Basic read with a rejected second start at cycle 6.
      pulses = 0;
      for (int k = 0; k <= 20; k++) begin
         if (k > 0) @(negedge clk);
         if (k >= 1 && k <= 4) begin
            check("basic_addr", {24'h0, a.bus_salida}, 32'h21);
            check("basic_hab", {31'h0, a.bus_habilitado}, 32'h1);
            check("basic_ad_wr", {30'h0, a.ad_n, a.wr_n}, 32'h0);
         end
         if (k >= 9 && k <= 12) check("basic_rd_n", {31'h0, a.rd_n}, 32'h0);
         if (k >= 1 && k <= 16) check("basic_ocupado", {31'h0, a.ocupado}, 32'h1);
         if (k == 17) begin
            check("basic_dato", {24'h0, a.dato_leido}, 32'h59);
            check("basic_valido", {31'h0, a.dato_valido}, 32'h1);
         end
         if (k >= 1 && a.dato_valido) pulses++;
         a.inicio      = (k == 0) || (k == 6);
         a.direccion   = (k == 6) ? 8'h33 : 8'h21;
         a.bus_entrada = (k >= 9 && k <= 12) ? 8'h59 : 8'($urandom);
      end
      check("busy_single_pulse", pulses, 1);

      // Sample window: only cycle 12 carries the wanted byte.
      for (int k = 0; k <= 20; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 17) check("window_dato", {24'h0, a.dato_leido}, 32'h07);
         a.inicio      = (k == 0);
         a.direccion   = 8'($urandom);
         a.bus_entrada = (k == 12) ? 8'h07 : 8'hFF;
      end

      // Back-to-back with inicio held high.
      for (int k = 0; k <= 38; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 17) begin
            check("b2b_valido1", {31'h0, a.dato_valido}, 32'h1);
            check("b2b_dato1", {24'h0, a.dato_leido}, 32'hA5);
         end
         if (k == 18) check("b2b_addr2", {24'h0, a.bus_salida}, 32'h11);
         if (k == 34) begin
            check("b2b_valido2", {31'h0, a.dato_valido}, 32'h1);
            check("b2b_dato2", {24'h0, a.dato_leido}, 32'h3C);
         end
         a.inicio      = (k < 34);
         a.direccion   = (k < 17) ? 8'h10 : 8'h11;
         a.bus_entrada = (k < 17) ? 8'hA5 : 8'h3C;
      end

      // T_FASE=1 instance.
      for (int k = 0; k <= 7; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 1) begin
            check("t1_addr", {24'h0, b.bus_salida}, 32'h02);
            check("t1_hab", {31'h0, b.bus_habilitado}, 32'h1);
         end
         if (k == 3) check("t1_rd_n", {31'h0, b.rd_n}, 32'h0);
         if (k == 5) begin
            check("t1_valido", {31'h0, b.dato_valido}, 32'h1);
            check("t1_dato", {24'h0, b.dato_leido}, 32'h9E);
         end
         b.inicio      = (k == 0);
         b.direccion   = 8'h02;
         b.bus_entrada = (k == 3) ? 8'h9E : 8'h00;
      end

      // Reset in the middle of LECTURA.
      for (int k = 0; k <= 10; k++) begin
         if (k > 0) @(negedge clk);
         a.inicio      = (k == 0);
         a.direccion   = 8'h44;
         a.bus_entrada = 8'h81;
      end
      reset = 1'b1;
      #1;
      check("rst_rd_n", {31'h0, a.rd_n}, 32'h1);
      check("rst_cs_n", {31'h0, a.cs_n}, 32'h1);
      check("rst_hab", {31'h0, a.bus_habilitado}, 32'h0);
      check("rst_dato", {24'h0, a.dato_leido}, 32'h0);
      check("rst_ocupado", {31'h0, a.ocupado}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (a.dato_valido) pulses++;
      end
      check("rst_no_pulse", pulses, 0);

      // Normal transaction after reset.
      for (int k = 0; k <= 18; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 17) check("post_rst_dato", {24'h0, a.dato_leido}, 32'hC3);
         a.inicio      = (k == 0);
         a.direccion   = 8'h5A;
         a.bus_entrada = (k == 12) ? 8'hC3 : 8'($urandom);
      end

      // Randomized traffic on both instances, checked by the model.
      for (int k = 0; k < 800; k++) begin
         @(negedge clk);
         a.inicio      = ($urandom_range(0, 3) == 0);
         a.direccion   = 8'($urandom);
         a.bus_entrada = 8'($urandom);
         b.inicio      = ($urandom_range(0, 2) == 0);
         b.direccion   = 8'($urandom);
         b.bus_entrada = 8'($urandom);
      end
      @(negedge clk);
      a.inicio = 1'b0;
      b.inicio = 1'b0;
      repeat (20) @(negedge clk);

      compare_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lector_bus_rtc.md
# lector_bus_rtc

- Read sequencer for the multiplexed 8-bit address/data bus to the RTC chip; it is the read-side counterpart of the write path's address/data output multiplexer.
- On a start pulse it runs one full read transaction:
  - drives the register address with the address strobe,
  - releases the bus,
  - strobes RD and samples the returned byte,
  - hands the byte to the controller with a one-cycle valid pulse.
- Sits between the RTC control FSM and the bidirectional pad logic.

## Interface

Parameters:
- T_FASE, 4, clock cycles per bus phase (≥1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- inicio  in  1  start request, sampled only in REPOSO
- direccion  in  8  RTC register address, latched when inicio is accepted
- bus_entrada  in  8  value currently present on the AD bus pads
- bus_salida  out  8  value to drive onto the AD bus
- bus_habilitado  out  1  pad output enable (1 = drive bus_salida)
- cs_n  out  1  chip select, active low
- ad_n  out  1  address strobe, active low
- wr_n  out  1  write strobe, active low (used to latch the address)
- rd_n  out  1  read strobe, active low
- dato_leido  out  8  last byte read, held until the next capture
- dato_valido  out  1  one-cycle pulse: dato_leido updated
- ocupado  out  1  transaction in progress

## Operation

- States: REPOSO, DIRECCION, LIBERA, LECTURA, FIN. Each non-idle state lasts exactly T_FASE cycles, timed by a phase counter that counts 0..T_FASE-1 and clears on every state change.
- REPOSO:
  - all strobes high, bus_habilitado=0, bus_salida=0x00.
  - On inicio=1: latch direccion, go to DIRECCION.
- DIRECCION:
  - cs_n=0, ad_n=0, wr_n=0, bus_habilitado=1, bus_salida=latched address.
- LIBERA:
  - cs_n=0, ad_n=1, wr_n=1, bus_habilitado=0, bus_salida=0x00 (turnaround).
- LECTURA:
  - cs_n=0, rd_n=0, bus released.
  - On the last cycle (counter = T_FASE-1), bus_entrada is registered into dato_leido at the closing edge.
- FIN:
  - all strobes high, bus released (recovery).
  - After T_FASE cycles go to REPOSO.
- dato_valido=1 during the first REPOSO cycle after FIN only.
- ocupado=1 in every state except REPOSO.
- inicio is ignored while ocupado=1. It is neither queued nor latched.
- direccion changes after acceptance have no effect on the transaction in progress.
- All strobe/enable outputs are registered (no combinational glitches). bus_habilitado and the ad_n/wr_n/rd_n strobes are never active in the same cycle in any combination other than those listed above.
- rd_n=0 and bus_habilitado=1 never occur together.

## Timing

- Reset (asynchronous, immediate):
  - state REPOSO, counter 0.
  - cs_n=ad_n=wr_n=rd_n=1, bus_habilitado=0, bus_salida=0x00.
  - dato_leido=0x00, dato_valido=0, ocupado=0.
- Reset mid-transaction: the bus is released and strobes deasserted within the reset assertion. No dato_valido pulse is produced, and dato_leido returns to 0x00.
- inicio high in cycle 0 (in REPOSO) gives:
  - DIRECCION: cycles 1..T_FASE
  - LIBERA: T_FASE+1..2·T_FASE
  - LECTURA: 2·T_FASE+1..3·T_FASE
  - FIN: 3·T_FASE+1..4·T_FASE
  - dato_valido: cycle 4·T_FASE+1
- Latency from inicio to dato_valido = 4·T_FASE+1 cycles.
- Sample point: bus_entrada is captured at the rising edge ending cycle 3·T_FASE. Values at any other time never reach dato_leido.
- A new inicio in the dato_valido cycle is accepted: back-to-back transaction period = 4·T_FASE+1 cycles.
- T_FASE=1 is legal: each phase lasts 1 cycle and latency is 5 cycles.

## Test plan

- Basic read, T_FASE=4:
  - Stimulus: direccion=0x21, inicio pulse at cycle 0, bus_entrada=0x59 during LECTURA.
  - Required: bus_salida=0x21 with bus_habilitado=1 and ad_n=wr_n=0 in cycles 1–4; rd_n=0 in cycles 9–12; dato_leido=0x59 and dato_valido=1 in cycle 17 only; ocupado=1 in cycles 1–16.
- Busy rejection:
  - Stimulus: second inicio with direccion=0x33 at cycle 6.
  - Required: the transaction continues with address 0x21; exactly one dato_valido pulse, at cycle 17.
- Back-to-back:
  - Stimulus: inicio held high continuously with addresses 0x10 then 0x11; bus returns 0xA5 then 0x3C.
  - Required: dato_valido at cycles 17 and 34; dato_leido 0xA5 then 0x3C.
- Sample window:
  - Stimulus: bus_entrada=0xFF everywhere except 0x07 in cycle 12.
  - Required: dato_leido=0x07.
- Reset mid-LECTURA:
  - Stimulus: reset asserted in cycle 10.
  - Required: rd_n=cs_n=1, bus_habilitado=0, dato_leido=0x00, ocupado=0 immediately; no dato_valido afterwards; the next inicio runs a normal transaction.
- T_FASE=1:
  - Stimulus: inicio at cycle 0 with direccion=0x02.
  - Required: address driven in cycle 1, rd_n=0 in cycle 3, dato_valido in cycle 5.
